dip_led_io: RTL

DIP_LED_IO -- requirements
Module: dip_led_io

---
 rtl/io_pkg.sv | 10 +
 rtl/dip_led_io_if.sv | 24 ++
 rtl/dip_led_io_debounce_channel.sv | 60 ++++++
 rtl/dip_led_io.sv | 81 ++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared encodings for the DIP switch / LED trainer block.
// Mode values select which internal state drives the LEDs.
package io_pkg;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_LATCH  = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

endpackage

// File: rtl/dip_led_io_if.sv
// Signal bundle for the DIP/LED trainer; master drives switches and mode,
// slave is the trainer block producing LED and debounced switch state.
interface dip_led_io_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] trainer_dip;
  logic [1:0]       mode;
  logic             clear;
  logic [WIDTH-1:0] led;
  logic [WIDTH-1:0] sw_state;
  logic [WIDTH-1:0] rise_pulse;

  modport master (
    output trainer_dip, mode, clear,
    input  led, sw_state, rise_pulse
  );

  modport slave (
    input  trainer_dip, mode, clear,
    output led, sw_state, rise_pulse
  );

endinterface

// File: rtl/dip_led_io_debounce_channel.sv
// One switch channel: two-flop synchronizer, stability counter, debounced
// level and a registered 0->1 edge pulse.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise_pulse,
  output logic rise_next
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_prev_q;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreement or an acceptance restarts it from zero.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = stable_q & ~stable_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      rise_q        <= 1'b0;
    end else begin
      sync1_q       <= din;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      rise_q        <= rise_d;
    end
  end

  assign stable     = stable_q;
  assign rise_pulse = rise_q;
  assign rise_next  = rise_d;

endmodule

// File: rtl/dip_led_io.sv
// DIP switch to LED trainer: per-channel debounce plus toggle, latch and
// rise-count state, with a registered LED mux chosen by mode.
module dip_led_io
  import io_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] trainer_dip,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] rise_pulse
);

  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] toggle_q, toggle_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] led_q, led_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .din       (trainer_dip[i]),
      .stable    (sw_state[i]),
      .rise_pulse(rise_pulse[i]),
      .rise_next (rise_next[i])
    );
  end

  // Mode state advances on the same edge that registers rise_pulse, so the
  // LED sees it one edge later; clear beats a coincident rise.
  always_comb begin
    toggle_d = toggle_q ^ rise_next;
    latch_d  = latch_q | rise_next;
    count_d  = count_q;
    if (|rise_next) begin
      count_d = count_q + WIDTH'(1);
    end
    if (clear) begin
      toggle_d = '0;
      latch_d  = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    led_d = sw_state;
    case (mode)
      MODE_PASS:   led_d = sw_state;
      MODE_TOGGLE: led_d = toggle_q;
      MODE_LATCH:  led_d = latch_q;
      MODE_COUNT:  led_d = count_q;
      default:     led_d = sw_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= '0;
      latch_q  <= '0;
      count_q  <= '0;
      led_q    <= '0;
    end else begin
      toggle_q <= toggle_d;
      latch_q  <= latch_d;
      count_q  <= count_d;
      led_q    <= led_d;
    end
  end

  assign led = led_q;

endmodule
